// File: rtl/line_pkg.sv
// Shared line-coordinate constants used by the renderer and all line position counters.
package line_pkg;

    localparam int unsigned LINE_W     = 16;
    localparam int unsigned LINE_Y_MIN = 18;
    localparam int unsigned LINE_Y_MAX = 630;

endpackage

// File: rtl/line_pos_counter_if.sv
// Control/status bundle between the button/switch front end and line_pos_counter.
interface line_pos_counter_if
    import line_pkg::*;
#(
    parameter int unsigned WIDTH = LINE_W
);
    logic             UP;
    logic             DW;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] pos;
    logic             at_max;
    logic             at_min;
    logic             bound_hit;

    modport master (
        output UP, DW, LD, D,
        input  pos, at_max, at_min, bound_hit
    );

    modport slave (
        input  UP, DW, LD, D,
        output pos, at_max, at_min, bound_hit
    );
endinterface

// File: rtl/move_tick_gen.sv
// Move-rate prescaler: issues one move strobe every RATE cycles of a steady single-direction request.
module move_tick_gen #(
    parameter int unsigned RATE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_up,
    input  logic req_dw,
    input  logic clr,
    output logic move_up,
    output logic move_dw
);
    localparam int unsigned CW = (RATE > 1) ? $clog2(RATE) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] eff;
    logic          last_up;
    logic          last_dw;
    logic          active;
    logic          same;
    logic          fire;

    // A new or changed request starts counting from zero in its first cycle
    always_comb begin
        cnt_nxt = '0;
        active  = req_up ^ req_dw;
        same    = active && (req_up == last_up) && (req_dw == last_dw);
        eff     = same ? cnt : '0;
        fire    = active && !clr && (eff == CW'(RATE - 1));
        if (active && !clr && !fire) begin
            cnt_nxt = eff + CW'(1);
        end
        move_up = fire && req_up;
        move_dw = fire && req_dw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            last_up <= 1'b0;
            last_dw <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            last_up <= req_up;
            last_dw <= req_dw;
        end
    end
endmodule

// File: rtl/line_pos_counter.sv
// Up/down screen-coordinate counter with rate prescaler, load clamp and bound-hit strobe.
// Define LINE_POS_WRAP_EN to wrap at the bounds instead of saturating.
module line_pos_counter
    import line_pkg::*;
#(
    parameter int unsigned WIDTH   = LINE_W,
    parameter int unsigned MIN_POS = LINE_Y_MIN,
    parameter int unsigned MAX_POS = LINE_Y_MAX,
    parameter int unsigned STEP    = 1,
    parameter int unsigned RATE    = 1
) (
    input  logic                clk,
    input  logic                reset,
    line_pos_counter_if.slave   bus
);
    if (!(MIN_POS < MAX_POS)) begin : g_bad_bounds
        $error("line_pos_counter: MIN_POS must be below MAX_POS");
    end
    if (!(longint'(MAX_POS) < (64'd1 << WIDTH))) begin : g_bad_width
        $error("line_pos_counter: MAX_POS does not fit in WIDTH bits");
    end
    if (!(STEP >= 1 && STEP <= MAX_POS - MIN_POS)) begin : g_bad_step
        $error("line_pos_counter: STEP out of range");
    end
    if (!(RATE >= 1)) begin : g_bad_rate
        $error("line_pos_counter: RATE must be at least 1");
    end

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_POS);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_POS);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   FLOOR_X = (WIDTH+1)'(MIN_POS + STEP);

    logic [WIDTH-1:0] pos_q;
    logic [WIDTH-1:0] pos_nxt;
    logic [WIDTH:0]   sum;
    logic             hit_q;
    logic             hit_nxt;
    logic             at_max_q;
    logic             at_min_q;
    logic             move_up;
    logic             move_dw;

    move_tick_gen #(.RATE(RATE)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .req_up  (bus.UP),
        .req_dw  (bus.DW),
        .clr     (bus.LD),
        .move_up (move_up),
        .move_dw (move_dw)
    );

    // Next position: load clamp first, then bounded move; wide sum avoids overflow
    always_comb begin
        pos_nxt = pos_q;
        hit_nxt = 1'b0;
        sum     = {1'b0, pos_q} + STEP_X;
        if (bus.LD) begin
            if (bus.D < MIN_W) begin
                pos_nxt = MIN_W;
            end else if (bus.D > MAX_W) begin
                pos_nxt = MAX_W;
            end else begin
                pos_nxt = bus.D;
            end
        end else if (move_up) begin
            if (sum <= MAX_X) begin
                pos_nxt = sum[WIDTH-1:0];
            end else begin
                hit_nxt = 1'b1;
`ifdef LINE_POS_WRAP_EN
                pos_nxt = MIN_W;
`else
                pos_nxt = MAX_W;
`endif
            end
        end else if (move_dw) begin
            if ({1'b0, pos_q} >= FLOOR_X) begin
                pos_nxt = pos_q - STEP_W;
            end else begin
                hit_nxt = 1'b1;
`ifdef LINE_POS_WRAP_EN
                pos_nxt = MAX_W;
`else
                pos_nxt = MIN_W;
`endif
            end
        end
    end

    // Flags are registered alongside pos so they always match it
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= MIN_W;
            hit_q    <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            pos_q    <= pos_nxt;
            hit_q    <= hit_nxt;
            at_max_q <= (pos_nxt == MAX_W);
            at_min_q <= (pos_nxt == MIN_W);
        end
    end

    assign bus.pos       = pos_q;
    assign bus.bound_hit = hit_q;
    assign bus.at_max    = at_max_q;
    assign bus.at_min    = at_min_q;
endmodule

// File: doc/line_pos_counter.md
# line_pos_counter

Parametrised up/down position counter for a moving line's screen coordinate. It replaces fixed-width cascaded counter chains that use hard-decoded bound flags. Width, bounds, step size and move rate are all generics, and it adds a rate prescaler, load clamping and a bound-hit strobe. The block sits between the button/switch inputs and the VGA line renderer, and supplies a registered coordinate plus min/max flags.

## Interface
- WIDTH, 16, coordinate width in bits
- MIN_POS, 18, lowest legal coordinate (reset value)
- MAX_POS, 630, highest legal coordinate
- STEP, 1, coordinate change per move
- RATE, 1, clock cycles per move while a direction is held (1 = move every cycle)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- UP  in  1  move toward MAX_POS while held
- DW  in  1  move toward MIN_POS while held
- LD  in  1  load D into position
- D  in  WIDTH  load value (switches)
- pos  out  WIDTH  current coordinate, registered
- at_max  out  1  pos == MAX_POS
- at_min  out  1  pos == MIN_POS
- bound_hit  out  1  one-cycle registered pulse: a move was clipped or wrapped at a bound

## Operation
- Legal parameters: MIN_POS < MAX_POS < 2^WIDTH; 1 ≤ STEP ≤ MAX_POS−MIN_POS; RATE ≥ 1. Violations fail at elaboration.
- Priority per cycle: reset > LD > move > hold.
- reset: pos=MIN_POS, prescaler=0, bound_hit=0.
- LD: pos = D clamped to [MIN_POS, MAX_POS]; prescaler cleared; bound_hit=0; UP/DW ignored that cycle.
- Direction request: exactly one of UP/DW high. UP&DW both high or both low means no request; the prescaler is cleared and pos holds.
- Prescaler: counts cycles while a request persists. A move fires on the cycle the count equals RATE−1, then the count returns to 0. A change of request direction clears the count.
- Up move: sum = pos+STEP computed in WIDTH+1 bits. If sum ≤ MAX_POS, pos=sum. Otherwise the bound rule (see Configuration) applies and bound_hit pulses.
- Down move: if pos ≥ MIN_POS+STEP, pos=pos−STEP. Otherwise the bound rule applies and bound_hit pulses. No unsigned underflow is ever formed.
- at_max and at_min are decoded from the pos register (equality compares), so they are valid in the same cycle as pos. Reset values: at_min=1, at_max=0.

## Timing
- Move latency: with a request held from cycle t, the first pos update is visible after edge t+RATE−1+1 (RATE=1: next edge). Later updates follow every RATE cycles.
- LD latency: 1 edge. Reset latency: 1 edge.
- bound_hit is high for exactly the one cycle following the clipped or wrapped move edge. It is never high in two consecutive cycles with RATE>1. With RATE=1 it repeats every cycle while pushing against a bound in saturate mode.
- Reset asserted mid-hold: the prescaler is discarded and counting restarts from 0 after reset deasserts.

## Configuration
- LINE_POS_WRAP_EN defined: a move crossing MAX_POS sets pos=MIN_POS, and a move crossing MIN_POS sets pos=MAX_POS. bound_hit pulses on each wrap.
- LINE_POS_WRAP_EN undefined (default): saturate. pos clamps to MAX_POS or MIN_POS, and bound_hit pulses on each clipped move. A move from exactly the bound leaves pos unchanged and still pulses.

## Structure
- Shared package line_pkg: default bound constants (LINE_Y_MIN=18, LINE_Y_MAX=630) and the coordinate width constant, shared with the renderer and the other line counters.
- One sub-module, move_tick_gen: the RATE prescaler. Inputs are clk, reset, req_up, req_dw and clr (LD); outputs are move_up and move_dw single-cycle strobes. The main block holds the position register, clamp/wrap arithmetic and flags.

## Test plan
- Reset with defaults → pos=18, at_min=1, at_max=0, bound_hit=0. Hold UP 5 cycles (RATE=1) → pos=23.
- LD with D=1000 → pos=630, at_max=1. LD with D=3 → pos=18. UP held simultaneously with LD is ignored.
- RATE=4, STEP=2: hold DW from pos=100 for 12 cycles → pos steps 98, 96, 94 at edges 4, 8, 12. Toggling DW off for one cycle restarts the 4-cycle count.
- Saturate build: pos=629, STEP=2, one UP move → pos=630, bound_hit one cycle. Next move → pos stays 630, bound_hit pulses again.
- Wrap build (LINE_POS_WRAP_EN): pos=18, one DW move → pos=630, bound_hit=1 for one cycle.
- UP&DW both high for 10 cycles → pos unchanged, prescaler stays 0. Reset asserted while UP held at pos=300 → pos=18 next cycle.
